mem_move_sequencer: RTL and testbench

Control stage sitting directly upstream of the 8-bit data registers in the memory-to-memory datapath. On a start command it moves `length` bytes from a source address range to a destination address range, one byte at a time. Each byte is read from synchronous memory, latched into an internal 8-bit staging register, then written back. The block generates every memory strobe and the staging-register write enable, and reports busy/done to the instruction controller.

---
 rtl/mem_move_sequencer.sv | 128 ++++++++++++
 tb/tb_mem_move_sequencer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_move_sequencer.sv
// mem_move_sequencer: byte-serial memory-to-memory copy controller.
// Ports: CLK/reset (async active-low); start, src_addr, dst_addr, length
// command inputs; mem_addr, mem_rd_en, mem_rdata, mem_wr_en, mem_wdata
// memory side; stage_we staging enable; busy, done, remaining status.
module mem_move_sequencer #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [7:0]        length,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_wr_en,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              stage_we,
    output logic              busy,
    output logic              done,
    output logic [7:0]        remaining
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_CAPTURE,
        S_WRITE,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_src;
    logic [ADDR_W-1:0] r_dst;
    logic [7:0]        r_count;
    logic [DATA_W-1:0] r_stage;
    logic              w_load;
    logic              w_capture;
    logic              w_advance;

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_load    = 1'b0;
        w_capture = 1'b0;
        w_advance = 1'b0;
        mem_addr  = '0;
        mem_rd_en = 1'b0;
        mem_wr_en = 1'b0;
        stage_we  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_load = 1'b1;
                    w_next = (length == 8'd0) ? S_DONE : S_READ;
                end
            end
            S_READ: begin
                busy      = 1'b1;
                mem_rd_en = 1'b1;
                mem_addr  = r_src;
                w_next    = S_CAPTURE;
            end
            S_CAPTURE: begin
                busy      = 1'b1;
                stage_we  = 1'b1;
                w_capture = 1'b1;
                mem_addr  = r_src;
                w_next    = S_WRITE;
            end
            S_WRITE: begin
                busy      = 1'b1;
                mem_wr_en = 1'b1;
                mem_addr  = r_dst;
                w_advance = 1'b1;
                // count still holds the pre-decrement value here
                w_next    = (r_count == 8'd1) ? S_DONE : S_READ;
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            r_src   <= '0;
            r_dst   <= '0;
            r_count <= '0;
            r_stage <= '0;
        end else begin
            if (w_load) begin
                r_src   <= src_addr;
                r_dst   <= dst_addr;
                r_count <= length;
            end
            if (w_capture) begin
                r_stage <= mem_rdata;
            end
            // pointers wrap modulo 2^ADDR_W by plain overflow
            if (w_advance) begin
                r_src   <= r_src + 1'b1;
                r_dst   <= r_dst + 1'b1;
                r_count <= r_count - 1'b1;
            end
        end
    end

    assign mem_wdata = r_stage;
    assign remaining = r_count;

endmodule

// File: tb/tb_mem_move_sequencer.sv
// tb_mem_move_sequencer: random and directed copies checked against
// a sequential byte-copy reference with a cycle-indexed timing model.
module tb_mem_move_sequencer;

    logic       CLK = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] src_addr;
    logic [7:0] dst_addr;
    logic [7:0] length;
    logic [7:0] mem_addr;
    logic       mem_rd_en;
    logic [7:0] mem_rdata;
    logic       mem_wr_en;
    logic [7:0] mem_wdata;
    logic       stage_we;
    logic       busy;
    logic       done;
    logic [7:0] remaining;

    logic [7:0] mem [0:255];
    logic [7:0] ref_mem [0:255];

    int checks = 0;
    int errors = 0;

    mem_move_sequencer #(
        .ADDR_W(8),
        .DATA_W(8)
    ) dut (
        .CLK      (CLK),
        .reset    (reset),
        .start    (start),
        .src_addr (src_addr),
        .dst_addr (dst_addr),
        .length   (length),
        .mem_addr (mem_addr),
        .mem_rd_en(mem_rd_en),
        .mem_rdata(mem_rdata),
        .mem_wr_en(mem_wr_en),
        .mem_wdata(mem_wdata),
        .stage_we (stage_we),
        .busy     (busy),
        .done     (done),
        .remaining(remaining)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (mem_rd_en) mem_rdata <= mem[mem_addr];
        if (mem_wr_en) mem[mem_addr] <= mem_wdata;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic logic [4:0] flags();
        return {busy, done, mem_rd_en, mem_wr_en, stage_we};
    endfunction

    task automatic mem_cmp(input string tag);
        int bad;
        bad = 0;
        for (int j = 0; j < 256; j++)
            if (mem[j] !== ref_mem[j]) bad++;
        chk(tag, bad, 0);
    endtask

    // spur: cycle index at which a stray start is pulsed (-1 = none);
    // a stray start is also always pulsed during the DONE cycle
    task automatic run_copy(input logic [7:0] s, input logic [7:0] d,
                            input logic [7:0] n, input int spur);
        logic [7:0] exp_data[$];
        logic [4:0] ef;
        logic [7:0] ea;
        int total, ph, b;
        exp_data = {};
        for (int i = 0; i < int'(n); i++) begin
            logic [7:0] v;
            v = ref_mem[8'(int'(s) + i)];
            exp_data.push_back(v);
            ref_mem[8'(int'(d) + i)] = v;
        end
        total = 3 * int'(n);
        @(negedge CLK);
        start = 1'b1;
        src_addr = s;
        dst_addr = d;
        length = n;
        @(negedge CLK);
        for (int k = 0; k <= total + 1; k++) begin
            ph = k % 3;
            b = k / 3;
            ea = '0;
            if (k < total) begin
                ef = {1'b1, 1'b0, ph == 0, ph == 2, ph == 1};
                ea = (ph == 2) ? 8'(int'(d) + b) : 8'(int'(s) + b);
            end else if (k == total) begin
                ef = 5'b01000;
            end else begin
                ef = 5'b00000;
            end
            chk("flags", flags(), ef);
            if (k < total) begin
                chk("addr", mem_addr, ea);
                chk("remaining", remaining, 8'(int'(n) - b));
                if (ph == 2) chk("wdata", mem_wdata, exp_data[b]);
            end
            if (k == total) chk("rem_done", remaining, 0);
            start = (k == spur) || (k == total);
            src_addr = 8'h40;
            dst_addr = 8'($urandom);
            length = 8'd5;
            @(negedge CLK);
        end
        start = 1'b0;
        mem_cmp("mem");
    endtask

    initial begin
        int n;
        for (int j = 0; j < 256; j++) begin
            mem[j] = 8'($urandom);
            ref_mem[j] = mem[j];
        end
        mem_rdata = '0;
        start = 1'b0;
        src_addr = '0;
        dst_addr = '0;
        length = '0;
        reset = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("rst_flags", flags(), 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_rem", remaining, 0);
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            chk("idle_flags", flags(), 0);
            chk("idle_addr", mem_addr, 0);
            chk("idle_rem", remaining, 0);
        end

        mem[8'h10] = 8'hA1;
        mem[8'h11] = 8'hB2;
        mem[8'h12] = 8'hC3;
        ref_mem[8'h10] = 8'hA1;
        ref_mem[8'h11] = 8'hB2;
        ref_mem[8'h12] = 8'hC3;
        run_copy(8'h10, 8'h80, 8'd3, -1);
        chk("basic0", mem[8'h80], 8'hA1);
        chk("basic1", mem[8'h81], 8'hB2);
        chk("basic2", mem[8'h82], 8'hC3);

        run_copy(8'h05, 8'h06, 8'd0, -1);
        run_copy(8'hFE, 8'hFF, 8'd4, -1);
        run_copy(8'h50, 8'hA0, 8'd2, 2);

        // reset during WRITE of byte 1 of 3: only byte 0 lands
        ref_mem[8'h60] = ref_mem[8'h20];
        @(negedge CLK);
        start = 1'b1;
        src_addr = 8'h20;
        dst_addr = 8'h60;
        length = 8'd3;
        @(negedge CLK);
        start = 1'b0;
        repeat (5) @(negedge CLK);
        chk("mid_wr", mem_wr_en, 1);
        chk("mid_addr", mem_addr, 8'h61);
        #2 reset = 1'b0;
        #1;
        chk("async_flags", flags(), 0);
        chk("async_addr", mem_addr, 0);
        chk("async_rem", remaining, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            chk("rst_hold", flags(), 0);
        end
        reset = 1'b1;
        @(negedge CLK);
        chk("post_rst", flags(), 0);
        mem_cmp("mem_partial");
        run_copy(8'h30, 8'h90, 8'd4, -1);

        for (int t = 0; t < 20; t++) begin
            n = $urandom_range(0, 12);
            run_copy(8'($urandom), 8'($urandom), 8'(n),
                     (n == 0) ? -1 : int'($urandom_range(0, 3 * n - 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
